norm_shift_detect: RTL and testbench

- Consumes the result of the propagate/generate significand adder: sum bits, carry-out and effective operation.
- Produces the normalization shift amount and direction for the post-add normalizer.
- Runs as a 2-stage valid/ready pipeline. The stage split mirrors the adder's mid-pipeline carry register, so wide significands close timing.

---
 rtl/fpu_norm_pkg.sv | 27 ++
 rtl/norm_shift_detect_if.sv | 29 ++
 rtl/lzd_chunk.sv | 25 ++
 rtl/norm_shift_detect.sv | 182 ++++++++++++++++++
 tb/tb_norm_shift_detect.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fpu_norm_pkg.sv
// Shared definitions for the FPU post-add normalization path: width helper,
// standard significand widths and the normalization result record.
package fpu_norm_pkg;

    localparam int SWR_SINGLE = 26;
    localparam int SWR_DOUBLE = 55;

    // Ceiling log2, usable in parameter defaults.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Shift field is sized for the widest supported significand.
    localparam int SHW_MAX = clog2(SWR_DOUBLE + 1);

    typedef struct packed {
        logic [SHW_MAX-1:0] shift;
        logic               right;
        logic               zero;
    } norm_res_t;

endpackage

// File: rtl/norm_shift_detect_if.sv
// Valid/ready bundle between the significand adder, the shift detector
// and the post-add normalizer.
interface norm_shift_detect_if import fpu_norm_pkg::*; #(
    parameter int SWR = SWR_SINGLE,
    parameter int SHW = clog2(SWR + 1)
) ();

    logic           valid_i;
    logic           ready_o;
    logic [SWR-1:0] S_i;
    logic           C_i;
    logic           sub_i;
    logic           valid_o;
    logic           ready_i;
    logic [SHW-1:0] shift_o;
    logic           right_o;
    logic           zero_o;

    modport slave (
        input  valid_i, S_i, C_i, sub_i, ready_i,
        output ready_o, valid_o, shift_o, right_o, zero_o
    );

    modport master (
        output valid_i, S_i, C_i, sub_i, ready_i,
        input  ready_o, valid_o, shift_o, right_o, zero_o
    );

endinterface

// File: rtl/lzd_chunk.sv
// Combinational leading-zero count and all-zero flag of a W-bit vector.
// An all-zero vector reports a count of W.
module lzd_chunk import fpu_norm_pkg::*; #(
    parameter int W  = 13,
    parameter int CW = clog2(W + 1)
) (
    input  logic [W-1:0]  vec_i,
    output logic [CW-1:0] cnt_o,
    output logic          zero_o
);

    // Scan upward so the most significant set bit is the last writer.
    always_comb begin
        cnt_o = CW'(W);
        for (int i = 0; i < W; i++) begin
            if (vec_i[i]) begin
                cnt_o = CW'(W - 1 - i);
            end else begin
                cnt_o = cnt_o;
            end
        end
        zero_o = ~|vec_i;
    end

endmodule

// File: rtl/norm_shift_detect.sv
// Two-stage valid/ready normalization shift detector for the post-add path.
// Define NORM_OUT_REG_EN to add a third output register stage (latency 3).
module norm_shift_detect import fpu_norm_pkg::*; #(
    parameter int SWR = SWR_SINGLE,
    parameter int SHW = clog2(SWR + 1)
) (
    input  logic              clk,
    input  logic              rst,
    norm_shift_detect_if.slave io
);

    localparam int HW  = SWR - SWR / 2;
    localparam int LW  = SWR / 2;
    localparam int HCW = clog2(HW + 1);
    localparam int LCW = clog2(LW + 1);

    typedef struct packed {
        logic [HCW-1:0] hi_cnt;
        logic           hi_z;
        logic [LCW-1:0] lo_cnt;
        logic           lo_z;
        logic           carry;
        logic           sub;
    } s1_t;

    logic [HCW-1:0] hi_cnt_s;
    logic           hi_z_s;
    logic [LCW-1:0] lo_cnt_s;
    logic           lo_z_s;

    logic      v1_q, v1_d;
    s1_t       s1_q, s1_d;
    logic      v2_q, v2_d;
    norm_res_t res2_q, res2_d;
    norm_res_t res_s;
    logic      en1_s, en2_s;

`ifdef NORM_OUT_REG_EN
    logic      v3_q, v3_d;
    norm_res_t out_q, out_d;
    logic      en3_s;
`endif

    lzd_chunk #(.W(HW)) u_lzd_hi (
        .vec_i  (io.S_i[SWR-1:LW]),
        .cnt_o  (hi_cnt_s),
        .zero_o (hi_z_s)
    );

    lzd_chunk #(.W(LW)) u_lzd_lo (
        .vec_i  (io.S_i[LW-1:0]),
        .cnt_o  (lo_cnt_s),
        .zero_o (lo_z_s)
    );

    // Stall chain: a stage may load when it is empty or its successor drains it.
    always_comb begin
`ifdef NORM_OUT_REG_EN
        en3_s = !v3_q || io.ready_i;
        en2_s = !v2_q || en3_s;
`else
        en2_s = !v2_q || io.ready_i;
`endif
        en1_s = !v1_q || en2_s;
    end

    assign io.ready_o = en1_s;

    // Stage 1 next state: capture both half-word counts and the carry context.
    always_comb begin
        v1_d = v1_q;
        s1_d = s1_q;
        if (en1_s) begin
            v1_d = io.valid_i;
            if (io.valid_i) begin
                s1_d.hi_cnt = hi_cnt_s;
                s1_d.hi_z   = hi_z_s;
                s1_d.lo_cnt = lo_cnt_s;
                s1_d.lo_z   = lo_z_s;
                s1_d.carry  = io.C_i;
                s1_d.sub    = io.sub_i;
            end else begin
                s1_d = s1_q;
            end
        end else begin
            v1_d = v1_q;
        end
    end

    // Shift decision; a carry out of a subtract is two's-complement wrap, not overflow.
    always_comb begin
        res_s = '0;
        if (s1_q.carry && !s1_q.sub) begin
            res_s.shift = SHW_MAX'(1'b1);
            res_s.right = 1'b1;
            res_s.zero  = 1'b0;
        end else if (!s1_q.hi_z) begin
            res_s.shift = SHW_MAX'(s1_q.hi_cnt);
            res_s.right = 1'b0;
            res_s.zero  = 1'b0;
        end else if (!s1_q.lo_z) begin
            res_s.shift = SHW_MAX'(SHW'(HW) + SHW'(s1_q.lo_cnt));
            res_s.right = 1'b0;
            res_s.zero  = 1'b0;
        end else begin
            res_s.shift = '0;
            res_s.right = 1'b0;
            res_s.zero  = 1'b1;
        end
    end

    // Stage 2 next state: holds its result while the consumer stalls.
    always_comb begin
        v2_d   = v2_q;
        res2_d = res2_q;
        if (en2_s) begin
            v2_d = v1_q;
            if (v1_q) begin
                res2_d = res_s;
            end else begin
                res2_d = res2_q;
            end
        end else begin
            v2_d = v2_q;
        end
    end

`ifdef NORM_OUT_REG_EN
    // Output stage next state: same load rule as the earlier stages.
    always_comb begin
        v3_d  = v3_q;
        out_d = out_q;
        if (en3_s) begin
            v3_d = v2_q;
            if (v2_q) begin
                out_d = res2_q;
            end else begin
                out_d = out_q;
            end
        end else begin
            v3_d = v3_q;
        end
    end

    // Output stage registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v3_q  <= 1'b0;
            out_q <= '0;
        end else begin
            v3_q  <= v3_d;
            out_q <= out_d;
        end
    end

    assign io.valid_o = v3_q;
    assign io.shift_o = SHW'(out_q.shift);
    assign io.right_o = out_q.right;
    assign io.zero_o  = out_q.zero;
`else
    assign io.valid_o = v2_q;
    assign io.shift_o = SHW'(res2_q.shift);
    assign io.right_o = res2_q.right;
    assign io.zero_o  = res2_q.zero;
`endif

    // Stage 1 and stage 2 registers; reset discards anything in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q   <= 1'b0;
            s1_q   <= '0;
            v2_q   <= 1'b0;
            res2_q <= '0;
        end else begin
            v1_q   <= v1_d;
            s1_q   <= s1_d;
            v2_q   <= v2_d;
            res2_q <= res2_d;
        end
    end

endmodule

// File: tb/tb_norm_shift_detect.sv
// Scoreboard bench for norm_shift_detect: expected results are queued on
// input transfer and compared in order on output transfer.
module tb_norm_shift_detect;
    import fpu_norm_pkg::*;

    localparam int SWR = 26;
    localparam int SHW = clog2(SWR + 1);
`ifdef NORM_OUT_REG_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    typedef struct {
        logic [SHW-1:0] shift;
        logic           right;
        logic           zero;
        int             acc;
        bit             chk_lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    norm_shift_detect_if #(.SWR(SWR)) bus ();

    norm_shift_detect #(.SWR(SWR)) dut (
        .clk (clk),
        .rst (rst),
        .io  (bus)
    );

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    exp_t sb[$];
    bit   hold_v   = 1'b0;
    logic [31:0] hold_val;
    exp_t mon_e;
    bit   rand_done;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: full-width leading-zero count, independent of the half split.
    function automatic exp_t model(input logic [SWR-1:0] s, input logic c, input logic sub);
        exp_t e;
        int   n;
        e.acc = 0;
        e.chk_lat = 1'b0;
        n = 0;
        if (c && !sub) begin
            e.shift = SHW'(1); e.right = 1'b1; e.zero = 1'b0;
        end else if (s == '0) begin
            e.shift = '0; e.right = 1'b0; e.zero = 1'b1;
        end else begin
            for (int i = SWR - 1; i >= 0; i--) begin
                if (s[i]) begin
                    n = SWR - 1 - i;
                    break;
                end
            end
            e.shift = SHW'(n); e.right = 1'b0; e.zero = 1'b0;
        end
        return e;
    endfunction

    task automatic send(input logic [SWR-1:0] s, input logic c, input logic sub, input bit lat);
        exp_t e;
        int   waited;
        waited = 0;
        e = model(s, c, sub);
        e.chk_lat = lat;
        @(negedge clk);
        bus.valid_i = 1'b1;
        bus.S_i     = s;
        bus.C_i     = c;
        bus.sub_i   = sub;
        #1;
        while (!bus.ready_o && waited < 200) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (bus.ready_o) begin
            e.acc = cyc;
            sb.push_back(e);
        end else begin
            check_eq("send_timeout", 32'd0, 32'd1);
        end
        @(posedge clk);
        #1;
        bus.valid_i = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (sb.size() != 0 && w < 300) begin
            @(negedge clk);
            w++;
        end
        repeat (2) @(negedge clk);
        check_eq("drain", sb.size(), 32'd0);
    endtask

    // Output monitor: in-order scoreboard compare plus stall-hold stability.
    always begin
        @(negedge clk);
        #1;
        if (rst) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v)
                check_eq("hold", {bus.valid_o, bus.shift_o, bus.right_o, bus.zero_o}, hold_val);
            if (bus.valid_o && bus.ready_i) begin
                if (sb.size() == 0) begin
                    check_eq("unexpected_out", 32'd1, 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    check_eq("shift", bus.shift_o, mon_e.shift);
                    check_eq("right", bus.right_o, mon_e.right);
                    check_eq("zero",  bus.zero_o,  mon_e.zero);
                    if (mon_e.chk_lat)
                        check_eq("latency", cyc - mon_e.acc, LAT);
                end
            end
            hold_v   = bus.valid_o && !bus.ready_i;
            hold_val = {24'd0, bus.valid_o, bus.shift_o, bus.right_o, bus.zero_o};
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b1;
        bus.valid_i = 1'b0;
        bus.S_i     = '0;
        bus.C_i     = 1'b0;
        bus.sub_i   = 1'b0;
        bus.ready_i = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check_eq("rst_valid", bus.valid_o, 32'd0);
        check_eq("rst_shift", bus.shift_o, 32'd0);
        check_eq("rst_right", bus.right_o, 32'd0);
        check_eq("rst_zero",  bus.zero_o,  32'd0);
        check_eq("rst_ready", bus.ready_o, 32'd1);
        @(negedge clk);
        rst = 1'b0;

        // Directed vectors, including the half-word boundary and carry cases.
        send(26'h2000000, 1'b0, 1'b0, 1'b1);
        send(26'h0001000, 1'b0, 1'b1, 1'b1);
        send(26'h0002000, 1'b0, 1'b0, 1'b1);
        send(26'h0000001, 1'b0, 1'b0, 1'b1);
        send(26'h0800000, 1'b1, 1'b0, 1'b1);
        send(26'h0800000, 1'b1, 1'b1, 1'b1);
        send(26'h0000000, 1'b0, 1'b1, 1'b1);
        send(26'h0000000, 1'b1, 1'b0, 1'b1);
        send(26'h3FFFFFF, 1'b0, 1'b0, 1'b1);
        drain();

        // Backpressure: two accepted, third held off until the consumer resumes.
        @(negedge clk);
        bus.ready_i = 1'b0;
        send(26'h0400000, 1'b0, 1'b0, 1'b0);
        send(26'h0000100, 1'b0, 1'b0, 1'b0);
        fork
            send(26'h0000004, 1'b0, 1'b1, 1'b0);
            begin
                repeat (3) @(negedge clk);
                #2;
                check_eq("stall_ready", bus.ready_o, 32'd0);
                check_eq("stall_valid", bus.valid_o, 32'd1);
                check_eq("stall_depth", sb.size(), 32'd2);
                @(negedge clk);
                bus.ready_i = 1'b1;
            end
        join
        drain();

        // Random traffic against random backpressure.
        rand_done = 1'b0;
        fork
            begin
                for (int k = 0; k < 40; k++) begin
                    logic [SWR-1:0] rs;
                    rs = SWR'($urandom()) >> $urandom_range(0, SWR);
                    send(rs, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(negedge clk);
                    bus.ready_i = ($urandom_range(0, 3) != 0);
                end
            end
        join
        @(negedge clk);
        bus.ready_i = 1'b1;
        drain();

        // Asynchronous reset with the pipeline full.
        @(negedge clk);
        bus.ready_i = 1'b0;
        send(26'h0010000, 1'b0, 1'b0, 1'b0);
        send(26'h0000010, 1'b0, 1'b0, 1'b0);
        repeat (LAT) @(negedge clk);
        #2;
        check_eq("full_before_rst", bus.valid_o, 32'd1);
        rst = 1'b1;
        #1;
        check_eq("async_rst_valid", bus.valid_o, 32'd0);
        check_eq("async_rst_ready", bus.ready_o, 32'd1);
        sb.delete();
        @(negedge clk);
        #3;
        rst = 1'b0;
        bus.ready_i = 1'b1;
        send(26'h0000800, 1'b0, 1'b0, 1'b1);
        drain();
        repeat (6) @(negedge clk);
        check_eq("post_rst_empty", sb.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
